// File: rtl/vector_exec.sv
// vector_exec: five-lane, 32-bit vector ALU that streams one element per
// cycle into a register-file write port.
//
// A start in IDLE latches both operand vectors, the opcode, the clamped
// element count and the destination base register. EXEC then issues
// element i to register (wa_base + i) mod 16. DONE raises a one-cycle
// completion pulse before the block returns to IDLE.
//
// Ports:
//   clk      in   1    rising-edge clock
//   reset    in   1    asynchronous active-high reset
//   start    in   1    request an operation (sampled only in IDLE)
//   op       in   2    00 ADD, 01 SUB, 10 AND, 11 ORR
//   vlen     in   4    element count, values above 5 clamp to 5
//   VsrcA    in   160  lanes A0..A4, lane i at bits [32i+31:32i]
//   VsrcB    in   160  lanes B0..B4, same packing
//   wa_base  in   4    destination base register
//   we3      out  1    register-file write enable
//   wa3      out  4    register-file write address
//   wd3      out  32   register-file write data
//   busy     out  1    high in EXEC and DONE
//   done     out  1    one-cycle completion pulse
//
// Build option: define VEXEC_SAT_EN to make ADD/SUB signed-saturating.
// Without it, ADD/SUB wrap modulo 2^32.

`timescale 1ns/1ps

module vector_exec #(
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [1:0]          op,
    input  logic [3:0]          vlen,
    input  logic [5*DATA_W-1:0] VsrcA,
    input  logic [5*DATA_W-1:0] VsrcB,
    input  logic [3:0]          wa_base,
    output logic                we3,
    output logic [3:0]          wa3,
    output logic [DATA_W-1:0]   wd3,
    output logic                busy,
    output logic                done
);

    localparam int LANES = 5;

    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

    state_t                state, state_nx;
    logic [5*DATA_W-1:0]   a_p0, b_p0;
    logic [1:0]            op_p0;
    logic [2:0]            len_p0;
    logic [2:0]            cnt_p0;
    logic [3:0]            base_p0;
    logic [2:0]            vlen_c;
    logic                  vld_p0;
    logic signed [DATA_W-1:0] lane_a, lane_b;
    logic [3:0]            addr;

    // ADD/SUB on signed lanes. When saturation is enabled, the sum is formed
    // one bit wider, so overflow shows up as the top two bits disagreeing.
    function automatic logic signed [DATA_W-1:0] arith(
        input logic signed [DATA_W-1:0] x,
        input logic signed [DATA_W-1:0] y,
        input logic                     sub
    );
`ifdef VEXEC_SAT_EN
        logic signed [DATA_W:0] s;
        s = sub ? ({x[DATA_W-1], x} - {y[DATA_W-1], y})
                : ({x[DATA_W-1], x} + {y[DATA_W-1], y});
        if (s[DATA_W] != s[DATA_W-1])
            return s[DATA_W] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
        return s[DATA_W-1:0];
`else
        return sub ? (x - y) : (x + y);
`endif
    endfunction

    function automatic logic signed [DATA_W-1:0] alu(
        input logic [1:0]               o,
        input logic signed [DATA_W-1:0] x,
        input logic signed [DATA_W-1:0] y
    );
        case (o)
            2'b00:   return arith(x, y, 1'b0);
            2'b01:   return arith(x, y, 1'b1);
            2'b10:   return x & y;
            default: return x | y;
        endcase
    endfunction

    assign vlen_c = (vlen > 4'd5) ? 3'd5 : vlen[2:0];
    assign vld_p0 = (state == EXEC);
    assign addr   = base_p0 + {1'b0, cnt_p0};

    // Operand latch / element counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            cnt_p0  <= '0;
            a_p0    <= '0;
            b_p0    <= '0;
            op_p0   <= '0;
            len_p0  <= '0;
            base_p0 <= '0;
        end else begin
            state <= state_nx;
            if (state == IDLE && start) begin
                a_p0    <= VsrcA;
                b_p0    <= VsrcB;
                op_p0   <= op;
                len_p0  <= vlen_c;
                base_p0 <= wa_base;
                cnt_p0  <= '0;
            end else if (state == EXEC) begin
                cnt_p0 <= cnt_p0 + 3'd1;
            end
        end
    end

    always_comb begin
        lane_a = '0;
        lane_b = '0;
        for (int i = 0; i < LANES; i++) begin
            if (cnt_p0 == 3'(i)) begin
                lane_a = a_p0[i*DATA_W +: DATA_W];
                lane_b = b_p0[i*DATA_W +: DATA_W];
            end
        end
    end

    // Element issue: outputs are combinational from latched state and cnt
    always_comb begin
        state_nx = state;
        we3      = 1'b0;
        wa3      = '0;
        wd3      = '0;
        busy     = 1'b0;
        done     = 1'b0;
        case (state)
            IDLE: begin
                if (start)
                    state_nx = (vlen_c != 3'd0) ? EXEC : DONE;
            end
            EXEC: begin
                busy = 1'b1;
                wa3  = addr;
                wd3  = alu(op_p0, lane_a, lane_b);
                // r15 is the PC: the element still takes its cycle but is not written.
                we3  = vld_p0 && (addr != 4'hF);
                if (cnt_p0 == len_p0 - 3'd1)
                    state_nx = DONE;
            end
            DONE: begin
                busy     = 1'b1;
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

endmodule

// File: doc/vector_exec.md
VECTOR_EXEC -- requirements
Module: vector_exec

Interface
REQ-001 SHALL have a single clock and an asynchronous, active-high reset.
REQ-002 SHALL have ports: clk  in  1  rising-edge clock.
REQ-003 SHALL have ports: reset  in  1  async active-high reset.
REQ-004 SHALL have ports: start  in  1  request a vector operation; sampled only in IDLE.
REQ-005 SHALL have ports: op  in  2  00 ADD, 01 SUB, 10 AND, 11 ORR.
REQ-006 SHALL have ports: vlen  in  4  element count; 0..5 legal, >5 clamped to 5.
REQ-007 SHALL have ports: VsrcA  in  160  lanes A0..A4, lane i at bits [32i+31:32i].
REQ-008 SHALL have ports: VsrcB  in  160  lanes B0..B4, same packing as VsrcA.
REQ-009 SHALL have ports: wa_base  in  4  destination base register.
REQ-010 SHALL have ports: we3  out  1  register-file write enable.
REQ-011 SHALL have ports: wa3  out  4  register-file write address.
REQ-012 SHALL have ports: wd3  out  32  register-file write data.
REQ-013 SHALL have ports: busy  out  1  high in EXEC and DONE.
REQ-014 SHALL have ports: done  out  1  one-cycle completion pulse.

Function
REQ-015 SHALL implement FSM IDLE -> EXEC -> DONE -> IDLE.
REQ-016 SHALL, in IDLE with start=1 at a clock edge, latch VsrcA, VsrcB, op, clamped vlen and wa_base, and clear element counter cnt to 0.
REQ-017 SHALL, on that edge, go to EXEC if clamped vlen>0; otherwise go directly to DONE with no writes.
REQ-018 SHALL, in EXEC with cnt=i, drive wa3=(wa_base+i) mod 16, wd3=A_i op B_i, and we3=1.
REQ-019 SHALL drive we3 combinationally from the latched state and cnt, so element i is written at the end of EXEC cycle i; element 0 lands one edge after start is sampled.
REQ-020 SHALL increment cnt each EXEC cycle and go to DONE on the edge where cnt=vlen-1.
REQ-021 SHALL, for a write address of 15 (the PC), force we3=0 for that element; the element still consumes its cycle.
REQ-022 SHALL assert done=1 for exactly one cycle in DONE, then return to IDLE.
REQ-023 SHALL ignore start outside IDLE; latched operands SHALL NOT change while busy.
REQ-024 SHALL hold we3=0, wa3=0, wd3=0 outside EXEC.
REQ-025 SHALL keep ADD/SUB results at 32 bits (carry dropped) and compute AND/ORR bitwise.
REQ-026 SHALL take vlen+2 cycles from the start edge to the return to IDLE (vlen>=1), and 2 cycles for vlen=0.
REQ-027 SHALL, when start is held high, begin the next operation on the first IDLE edge after done.

Reset
REQ-028 SHALL, on reset assertion and independent of clk, force state=IDLE, cnt=0, and all latched registers to 0.
REQ-029 SHALL drive we3=0, wa3=0, wd3=0, busy=0, done=0 immediately on reset.
REQ-030 SHALL abort any operation in progress on mid-operation reset; no further writes issue and done SHALL NOT pulse.
REQ-031 SHALL NOT sample start while reset is asserted.

Configuration
REQ-032 SHALL, with VEXEC_SAT_EN defined, make ADD and SUB signed-saturating: clamp to 0x7FFFFFFF on positive overflow and to 0x80000000 on negative overflow.
REQ-033 SHALL, without VEXEC_SAT_EN, make ADD and SUB wrap modulo 2^32; AND and ORR are unaffected either way.

Verification
REQ-034 Bench SHALL cover ADD: vlen=3, wa_base=4, A={1,2,3}, B={10,20,30} -> writes r4=11, r5=22, r6=33 on consecutive cycles, then done one cycle later.
REQ-035 Bench SHALL cover the PC hole: vlen=3, wa_base=14, op=AND -> write to r14, we3=0 for address 15, write to r0 (wrap); done at cycle 4.
REQ-036 Bench SHALL cover vlen=0 and vlen=9: 0 -> no writes, done one cycle after start; 9 -> exactly 5 writes.
REQ-037 Bench SHALL cover overflow: ADD A0=0x7FFFFFFF, B0=1 -> wd3=0x80000000 without VEXEC_SAT_EN, and 0x7FFFFFFF with it.
REQ-038 Bench SHALL cover mid-operation reset: reset during EXEC at cnt=1 of vlen=5 -> we3 falls at once, busy=0, no done pulse, the next start runs normally.
REQ-039 Bench SHALL cover start while busy: second start pulse during EXEC -> ignored, latched operands unchanged, single done.
